// File: rtl/dmem_responder.sv
// Fixed-latency data memory responder: accepts one load/store in IDLE and completes it LATENCY cycles later.
// Optional macro DMEM_ADDR_CHECK_EN adds out-of-range detection and the Error port.
module dmem_responder #(
  parameter int NBITS   = 8,
  parameter int DEPTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NBITS-1:2] Address,
  input  logic [NBITS-1:0] WriteData,
  input  logic             MemWrite,
  input  logic             MemRead,
  output logic [NBITS-1:0] ReadData,
  output logic             Ready,
  output logic             Busy
`ifdef DMEM_ADDR_CHECK_EN
  ,
  output logic             Error
`endif
);

  localparam int AW = NBITS - 2;
  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] COUNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t           state, nextState;
  logic [3:0]       count;
  logic [AW-1:0]    latchAddr;
  logic [NBITS-1:0] latchData;
  logic             latchWrite;
  logic [NBITS-1:0] mem [DEPTH];
  logic             accept, execute, inRange;
  logic [IDXW-1:0]  memIdx;

  assign accept  = (state == IDLE) && (MemRead || MemWrite);
  assign execute = (state == BUSY) && (count == 4'd0);
  assign memIdx  = latchAddr[IDXW-1:0];
  assign Ready   = (state == RESP);
  assign Busy    = (state != IDLE);

`ifdef DMEM_ADDR_CHECK_EN
  logic errFlag;
  assign inRange = 32'(latchAddr) < DEPTH;
  assign Error   = errFlag && (state == RESP);
`else
  // Without the check the address simply wraps onto the low index bits.
  logic unusedAddr;
  assign inRange    = 1'b1;
  assign unusedAddr = ^latchAddr;
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept) nextState = BUSY;
      BUSY:    if (count == 4'd0) nextState = RESP;
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Request latch, latency counter and memory array; the request is executed on the last BUSY edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      count      <= 4'd0;
      latchAddr  <= '0;
      latchData  <= '0;
      latchWrite <= 1'b0;
      ReadData   <= '0;
`ifdef DMEM_ADDR_CHECK_EN
      errFlag    <= 1'b0;
`endif
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (accept) begin
        count      <= COUNT_INIT;
        latchAddr  <= Address;
        latchData  <= WriteData;
        latchWrite <= MemWrite;
      end else if ((state == BUSY) && (count != 4'd0)) begin
        count <= count - 4'd1;
      end
      if (execute) begin
`ifdef DMEM_ADDR_CHECK_EN
        errFlag <= !inRange;
`endif
        if (latchWrite) begin
          if (inRange) mem[memIdx] <= latchData;
        end else begin
          ReadData <= inRange ? mem[memIdx] : '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: a table of directed transactions plus hand-written reset/disturbance sequences.
// Expectations follow DMEM_ADDR_CHECK_EN when the bench is built with it.
module tb_dmem_responder;

  localparam int NBITS = 8;
  localparam int DEPTH = 32;
  localparam int LAT   = 2;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [NBITS-1:2] Address = '0;
  logic [NBITS-1:0] WriteData = '0;
  logic             MemWrite = 1'b0;
  logic             MemRead = 1'b0;
  logic [NBITS-1:0] ReadData;
  logic             Ready;
  logic             Busy;
  logic             Error;

  int checks = 0;
  int errors = 0;

  dmem_responder #(.NBITS(NBITS), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clock(clock),
    .reset(reset),
    .Address(Address),
    .WriteData(WriteData),
    .MemWrite(MemWrite),
    .MemRead(MemRead),
    .ReadData(ReadData),
    .Ready(Ready),
    .Busy(Busy)
`ifdef DMEM_ADDR_CHECK_EN
    ,
    .Error(Error)
`endif
  );

`ifndef DMEM_ADDR_CHECK_EN
  assign Error = 1'b0;
`endif

  always #5 clock = ~clock;

  typedef struct {
    logic       wr;
    logic       rd;
    logic [5:0] addr;
    logic [7:0] data;
    logic [7:0] expRd;
    logic       expErr;
  } vec_t;

  vec_t vecs[10];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic rd, input logic [5:0] addr, input logic [7:0] data);
    MemWrite  = wr;
    MemRead   = rd;
    Address   = addr;
    WriteData = data;
  endtask

  // Called just after a negedge; returns just after the negedge following the Ready pulse.
  task automatic runOp(input string name, input logic wr, input logic rd, input logic [5:0] addr,
                       input logic [7:0] data, input logic [7:0] expRd, input logic expErr, input bit disturb);
    int cycles;
    bit busyLow;
    cycles  = 0;
    busyLow = 0;
    applyStimulus(wr, rd, addr, data);
    @(posedge clock);
    forever begin
      @(negedge clock);
      cycles++;
      if (Ready === 1'b1 || cycles > 20) break;
      if (Busy !== 1'b1) busyLow = 1;
      if (disturb) applyStimulus(1'b1, cycles[0], 6'd9, 8'hEE);
      else         applyStimulus(1'b0, 1'b0, 6'd0, 8'h00);
    end
    applyStimulus(1'b0, 1'b0, 6'd0, 8'h00);
    checkOutput({name, " latency"}, cycles, LAT + 1);
    checkOutput({name, " busyInFlight"}, {31'd0, busyLow}, 32'd0);
    checkOutput({name, " busyInResp"}, {31'd0, Busy}, 32'd1);
    checkOutput({name, " readData"}, {24'd0, ReadData}, {24'd0, expRd});
    checkOutput({name, " error"}, {31'd0, Error}, {31'd0, expErr});
    @(negedge clock);
    checkOutput({name, " readyPulse"}, {31'd0, Ready}, 32'd0);
    checkOutput({name, " busyIdle"}, {31'd0, Busy}, 32'd0);
  endtask

  logic oobErr;
  logic [7:0] wrapRd;

  initial begin
`ifdef DMEM_ADDR_CHECK_EN
    oobErr = 1'b1;
    wrapRd = 8'h00;
`else
    oobErr = 1'b0;
    wrapRd = 8'h5A;
`endif
    //           wr    rd    addr   data   expRd   expErr
    vecs[0] = '{1'b0, 1'b1, 6'd5,  8'h00, 8'h00, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 6'd7,  8'hA5, 8'h00, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 6'd7,  8'h00, 8'hA5, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 6'd2,  8'h3C, 8'hA5, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 6'd2,  8'h00, 8'h3C, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 6'd33, 8'h5A, 8'h3C, oobErr};
    vecs[6] = '{1'b0, 1'b1, 6'd1,  8'h00, wrapRd, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 6'd33, 8'h00, wrapRd, oobErr};
    vecs[8] = '{1'b1, 1'b0, 6'd31, 8'h77, wrapRd, 1'b0};
    vecs[9] = '{1'b0, 1'b1, 6'd31, 8'h00, 8'h77, 1'b0};

    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("reset readData", {24'd0, ReadData}, 32'd0);
    checkOutput("reset ready", {31'd0, Ready}, 32'd0);
    checkOutput("reset busy", {31'd0, Busy}, 32'd0);
    checkOutput("reset error", {31'd0, Error}, 32'd0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 10; i++)
      runOp($sformatf("vec%0d", i), vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data,
            vecs[i].expRd, vecs[i].expErr, 1'b0);

    // Inputs wiggled while busy must not affect the latched write.
    runOp("disturbWr", 1'b1, 1'b0, 6'd1, 8'h11, 8'h77, 1'b0, 1'b1);
    runOp("disturbRd1", 1'b0, 1'b1, 6'd1, 8'h00, 8'h11, 1'b0, 1'b0);
    runOp("disturbRd9", 1'b0, 1'b1, 6'd9, 8'h00, 8'h00, 1'b0, 1'b0);

    // Reset one cycle after accept aborts the write and clears everything.
    applyStimulus(1'b1, 1'b0, 6'd3, 8'hFF);
    @(posedge clock);
    @(negedge clock);
    applyStimulus(1'b0, 1'b0, 6'd0, 8'h00);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("abort busy", {31'd0, Busy}, 32'd0);
    checkOutput("abort readData", {24'd0, ReadData}, 32'd0);
    reset = 1'b0;
    begin
      int readySeen;
      readySeen = 0;
      repeat (5) begin
        @(negedge clock);
        if (Ready === 1'b1) readySeen++;
      end
      checkOutput("abort noReady", readySeen, 0);
    end
    runOp("abortRd3", 1'b0, 1'b1, 6'd3, 8'h00, 8'h00, 1'b0, 1'b0);

    // Reset wins over a request sampled on the same edge.
    applyStimulus(1'b0, 1'b1, 6'd3, 8'h00);
    reset = 1'b1;
    @(negedge clock);
    checkOutput("resetPriority busy", {31'd0, Busy}, 32'd0);
    applyStimulus(1'b0, 1'b0, 6'd0, 8'h00);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("resetPriority idle", {31'd0, Busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
